// File: rtl/arb_pkg.sv
// Shared types and constants for the queued grant arbiter.
package arb_pkg;

    localparam int unsigned N_REQ = 4;
    localparam int unsigned ID_W  = 2;

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        RECOVER
    } arb_state_t;

    function automatic logic [N_REQ-1:0] onehot(input logic [ID_W-1:0] id);
        logic [N_REQ-1:0] v;
        v     = '0;
        v[id] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/queued_grant_arbiter_id_queue.sv
// Ordered 4-entry id queue: one pop and a compacted ordered push list per cycle.
module id_queue
    import arb_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_pop,
    input  logic             i_first_vld,
    input  logic [ID_W-1:0]  i_first_id,
    input  logic [N_REQ-1:0] i_push_mask,
    output logic [ID_W-1:0]  o_head,
    output logic [2:0]       o_count,
    output logic [N_REQ-1:0] o_pending
);

    logic [ID_W-1:0]  r_q [N_REQ];
    logic [2:0]       r_count;
    logic [N_REQ-1:0] r_pending;

    logic [ID_W-1:0]  w_q [N_REQ];
    logic [2:0]       w_count;
    logic [N_REQ-1:0] w_pending;

    // Pop shifts first; pushes then append behind whatever remains, in order.
    always_comb begin
        w_q       = r_q;
        w_count   = r_count;
        w_pending = r_pending;
        if (i_pop && r_count != 3'd0) begin
            w_pending = w_pending & ~onehot(r_q[0]);
            for (int unsigned i = 0; i < N_REQ - 1; i++) begin
                w_q[i] = r_q[i+1];
            end
            w_q[N_REQ-1] = '0;
            w_count      = w_count - 3'd1;
        end
        if (i_first_vld && w_count < 3'(N_REQ)) begin
            w_q[w_count[ID_W-1:0]] = i_first_id;
            w_pending              = w_pending | onehot(i_first_id);
            w_count                = w_count + 3'd1;
        end
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (i_push_mask[i] && w_count < 3'(N_REQ)) begin
                w_q[w_count[ID_W-1:0]] = ID_W'(i);
                w_pending              = w_pending | onehot(ID_W'(i));
                w_count                = w_count + 3'd1;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int unsigned i = 0; i < N_REQ; i++) begin
                r_q[i] <= '0;
            end
            r_count   <= '0;
            r_pending <= '0;
        end else begin
            r_q       <= w_q;
            r_count   <= w_count;
            r_pending <= w_pending;
        end
    end

    assign o_head    = r_q[0];
    assign o_count   = r_count;
    assign o_pending = r_pending;

endmodule

// File: rtl/queued_grant_arbiter.sv
// Four-requester first-come arbiter with bounded hold time and timeout re-enqueue.
module queued_grant_arbiter
    import arb_pkg::*;
#(
    parameter int unsigned HOLD_MAX = 15
)
(
    input  logic             CLOCK,
    input  logic             RESET,
    input  logic [N_REQ-1:0] REQUEST,
    output logic [N_REQ-1:0] GRANT_O,
    output logic             BUSY,
    output logic [2:0]       QUEUE_COUNT,
    output logic             TIMEOUT
);

    localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

    arb_state_t       r_state;
    logic [N_REQ-1:0] r_req_q;
    logic [N_REQ-1:0] r_grant;
    logic [ID_W-1:0]  r_owner;
    logic [7:0]       r_hold;
    logic             r_busy;
    logic             r_timeout;

    logic [ID_W-1:0]  w_head;
    logic [2:0]       w_count;
    logic [N_REQ-1:0] w_pending;
    logic [N_REQ-1:0] w_new_req;
    logic             w_pop;
    logic             w_owner_req;
    logic             w_requeue;

    // r_grant is non-zero only in GRANT, so it doubles as the owner mask.
    assign w_new_req   = REQUEST & ~r_req_q & ~w_pending & ~r_grant;
    assign w_owner_req = REQUEST[r_owner];
    assign w_pop       = (r_state == IDLE) && (w_count != 3'd0);
    assign w_requeue   = (r_state == GRANT) && w_owner_req && (r_hold == HOLD_LAST);

    id_queue u_queue (
        .i_clk       (CLOCK),
        .i_rst       (RESET),
        .i_pop       (w_pop),
        .i_first_vld (w_requeue),
        .i_first_id  (r_owner),
        .i_push_mask (w_new_req),
        .o_head      (w_head),
        .o_count     (w_count),
        .o_pending   (w_pending)
    );

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            r_state   <= IDLE;
            r_req_q   <= '0;
            r_grant   <= '0;
            r_owner   <= '0;
            r_hold    <= '0;
            r_busy    <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_req_q   <= REQUEST;
            r_timeout <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_pop && REQUEST[w_head]) begin
                        r_state <= GRANT;
                        r_owner <= w_head;
                        r_grant <= onehot(w_head);
                        r_busy  <= 1'b1;
                        r_hold  <= '0;
                    end
                end
                GRANT: begin
                    if (!w_owner_req) begin
                        r_state <= RECOVER;
                        r_grant <= '0;
                        r_busy  <= 1'b0;
                    end else if (r_hold == HOLD_LAST) begin
                        r_state   <= RECOVER;
                        r_grant   <= '0;
                        r_busy    <= 1'b0;
                        r_timeout <= 1'b1;
                    end else begin
                        r_hold <= r_hold + 8'd1;
                    end
                end
                RECOVER: r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign GRANT_O     = r_grant;
    assign BUSY        = r_busy;
    assign QUEUE_COUNT = w_count;
    assign TIMEOUT     = r_timeout;

endmodule

// File: tb/tb_queued_grant_arbiter.sv
// Cycle-level vector bench for queued_grant_arbiter (HOLD_MAX = 4).
module tb_queued_grant_arbiter;

    logic       CLOCK = 1'b0;
    logic       RESET;
    logic [3:0] REQUEST;
    logic [3:0] GRANT_O;
    logic       BUSY;
    logic [2:0] QUEUE_COUNT;
    logic       TIMEOUT;

    queued_grant_arbiter #(.HOLD_MAX(4)) dut (
        .CLOCK       (CLOCK),
        .RESET       (RESET),
        .REQUEST     (REQUEST),
        .GRANT_O     (GRANT_O),
        .BUSY        (BUSY),
        .QUEUE_COUNT (QUEUE_COUNT),
        .TIMEOUT     (TIMEOUT)
    );

    always #5 CLOCK = ~CLOCK;

    typedef struct {
        logic [3:0] req;
        logic [3:0] grant;
        logic       busy;
        logic [2:0] cnt;
        logic       tmo;
    } vec_t;

    typedef struct {
        logic [3:0] grant;
        logic       busy;
        logic [2:0] cnt;
        logic       tmo;
        string      tag;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic add(input logic [3:0] r, input logic [3:0] g, input logic [2:0] c, input logic t);
        vec_t v;
        v.req   = r;
        v.grant = g;
        v.busy  = (g != 4'b0000);
        v.cnt   = c;
        v.tmo   = t;
        tbl.push_back(v);
    endtask

    task automatic expect_out(input logic [3:0] g, input logic [2:0] c, input logic t, input string tag);
        exp_t e;
        e.grant = g;
        e.busy  = (g != 4'b0000);
        e.cnt   = c;
        e.tmo   = t;
        e.tag   = tag;
        sb.push_back(e);
    endtask

    task automatic check_out();
        exp_t e;
        n_cmp++;
        if (sb.size() == 0) begin
            n_bad++;
            $display("FAIL scoreboard_empty: got no expected entry, required one");
            return;
        end
        e = sb.pop_front();
        if ({GRANT_O, BUSY, QUEUE_COUNT, TIMEOUT} !== {e.grant, e.busy, e.cnt, e.tmo}) begin
            n_bad++;
            $display("FAIL %s: got grant=%b busy=%b count=%0d timeout=%b, required grant=%b busy=%b count=%0d timeout=%b",
                     e.tag, GRANT_O, BUSY, QUEUE_COUNT, TIMEOUT, e.grant, e.busy, e.cnt, e.tmo);
        end
    endtask

    task automatic step(input logic [3:0] r, input logic [3:0] g, input logic [2:0] c, input logic t, input string tag);
        REQUEST = r;
        expect_out(g, c, t, tag);
        @(posedge CLOCK);
        #1;
        check_out();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, required finish before time limit");
        $fatal(1);
    end

    initial begin
        // Arrival order 2, 0, 3; each release gives RECOVER then IDLE before the next grant.
        add(4'b0100, 4'b0000, 3'd1, 1'b0);
        add(4'b0101, 4'b0100, 3'd1, 1'b0);
        add(4'b1101, 4'b0100, 3'd2, 1'b0);
        add(4'b1001, 4'b0000, 3'd2, 1'b0);
        add(4'b1001, 4'b0000, 3'd2, 1'b0);
        add(4'b1001, 4'b0001, 3'd1, 1'b0);
        add(4'b1000, 4'b0000, 3'd1, 1'b0);
        add(4'b1000, 4'b0000, 3'd1, 1'b0);
        add(4'b1000, 4'b1000, 3'd0, 1'b0);
        add(4'b0000, 4'b0000, 3'd0, 1'b0);
        add(4'b0000, 4'b0000, 3'd0, 1'b0);
        // Timeout round-robin between 1 and 3, then 3 withdraws while queued.
        add(4'b1010, 4'b0000, 3'd2, 1'b0);
        add(4'b1010, 4'b0010, 3'd1, 1'b0);
        add(4'b1010, 4'b0010, 3'd1, 1'b0);
        add(4'b1010, 4'b0010, 3'd1, 1'b0);
        add(4'b1010, 4'b0010, 3'd1, 1'b0);
        add(4'b1010, 4'b0000, 3'd2, 1'b1);
        add(4'b1010, 4'b0000, 3'd2, 1'b0);
        add(4'b1010, 4'b1000, 3'd1, 1'b0);
        add(4'b1010, 4'b1000, 3'd1, 1'b0);
        add(4'b1010, 4'b1000, 3'd1, 1'b0);
        add(4'b1010, 4'b1000, 3'd1, 1'b0);
        add(4'b1010, 4'b0000, 3'd2, 1'b1);
        add(4'b1010, 4'b0000, 3'd2, 1'b0);
        add(4'b1010, 4'b0010, 3'd1, 1'b0);
        add(4'b0000, 4'b0000, 3'd1, 1'b0);
        add(4'b0000, 4'b0000, 3'd1, 1'b0);
        add(4'b0000, 4'b0000, 3'd0, 1'b0);
        add(4'b0000, 4'b0000, 3'd0, 1'b0);
        // Withdrawal: queue [1,2], 1 drops and is skipped.
        add(4'b0001, 4'b0000, 3'd1, 1'b0);
        add(4'b0001, 4'b0001, 3'd0, 1'b0);
        add(4'b0011, 4'b0001, 3'd1, 1'b0);
        add(4'b0111, 4'b0001, 3'd2, 1'b0);
        add(4'b0100, 4'b0000, 3'd2, 1'b0);
        add(4'b0100, 4'b0000, 3'd2, 1'b0);
        add(4'b0100, 4'b0000, 3'd1, 1'b0);
        add(4'b0100, 4'b0100, 3'd0, 1'b0);
        add(4'b0000, 4'b0000, 3'd0, 1'b0);
        add(4'b0000, 4'b0000, 3'd0, 1'b0);
        // Push of 1 and 2 in the same cycle as the pop of 0.
        add(4'b0001, 4'b0000, 3'd1, 1'b0);
        add(4'b0111, 4'b0001, 3'd2, 1'b0);
        add(4'b0110, 4'b0000, 3'd2, 1'b0);
        add(4'b0110, 4'b0000, 3'd2, 1'b0);
        add(4'b0110, 4'b0010, 3'd1, 1'b0);
        add(4'b0100, 4'b0000, 3'd1, 1'b0);
        add(4'b0100, 4'b0000, 3'd1, 1'b0);
        add(4'b0100, 4'b0100, 3'd0, 1'b0);
        add(4'b0000, 4'b0000, 3'd0, 1'b0);
        add(4'b0000, 4'b0000, 3'd0, 1'b0);
        // Re-raise of a pending requester adds no duplicate entry.
        add(4'b0010, 4'b0000, 3'd1, 1'b0);
        add(4'b0010, 4'b0010, 3'd0, 1'b0);
        add(4'b0011, 4'b0010, 3'd1, 1'b0);
        add(4'b0010, 4'b0010, 3'd1, 1'b0);
        add(4'b0011, 4'b0010, 3'd1, 1'b0);
        add(4'b0001, 4'b0000, 3'd1, 1'b0);
        add(4'b0001, 4'b0000, 3'd1, 1'b0);
        add(4'b0001, 4'b0001, 3'd0, 1'b0);
        add(4'b0000, 4'b0000, 3'd0, 1'b0);
        add(4'b0000, 4'b0000, 3'd0, 1'b0);

        RESET   = 1'b1;
        REQUEST = 4'b0000;
        @(posedge CLOCK);
        @(posedge CLOCK);
        #1;
        expect_out(4'b0000, 3'd0, 1'b0, "reset_state");
        check_out();
        RESET = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].req, tbl[i].grant, tbl[i].cnt, tbl[i].tmo, $sformatf("vec%0d", i));
        end

        // Reset in the middle of a grant, with every request held high across release.
        step(4'b1111, 4'b0000, 3'd4, 1'b0, "rst_fill");
        step(4'b1111, 4'b0001, 3'd3, 1'b0, "rst_pre_grant");
        #2;
        RESET = 1'b1;
        #1;
        expect_out(4'b0000, 3'd0, 1'b0, "rst_async_clear");
        check_out();
        @(posedge CLOCK);
        #1;
        expect_out(4'b0000, 3'd0, 1'b0, "rst_held");
        check_out();
        RESET = 1'b0;
        step(4'b1111, 4'b0000, 3'd4, 1'b0, "rst_release_edge");
        step(4'b1111, 4'b0001, 3'd3, 1'b0, "rst_first_grant");
        step(4'b1111, 4'b0001, 3'd3, 1'b0, "rst_hold");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
